// File: rtl/ball_ctrl_pkg.sv
// Shared types and constants for the pong ball controller: FSM states,
// per-axis direction encodings and the serve cell.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        PLAY,
        POINT,
        OVER
    } state_t;

    localparam logic [1:0] DIR_HOLD = 2'b00;
    localparam logic [1:0] DIR_POS  = 2'b01;
    localparam logic [1:0] DIR_NEG  = 2'b11;

    localparam int SERVE_X = 3;
    localparam int SERVE_Y = 4;

    function automatic logic [1:0] dir_flip(input logic [1:0] dir);
        return (dir == DIR_POS) ? DIR_NEG : DIR_POS;
    endfunction

endpackage

// File: rtl/ball_ctrl_paddle_hit.sv
// Combinational paddle range check: reports whether the ball row lies on the
// paddle and whether it is the paddle's top or bottom cell.
module paddle_hit #(
    parameter int BIT_OF_WIDTH = 3,
    parameter int PADDLE_LEN   = 3
) (
    input  logic [BIT_OF_WIDTH-1:0] ball_y,
    input  logic [BIT_OF_WIDTH-1:0] pad_y,
    output logic                    hit,
    output logic                    top_edge,
    output logic                    bottom_edge
);

    // One extra bit so a paddle reaching past the last row cannot wrap to 0.
    logic [BIT_OF_WIDTH:0] top_w;
    logic [BIT_OF_WIDTH:0] bot_w;
    logic [BIT_OF_WIDTH:0] ball_w;

    assign top_w  = {1'b0, pad_y};
    assign ball_w = {1'b0, ball_y};
    assign bot_w  = top_w + (BIT_OF_WIDTH+1)'(PADDLE_LEN - 1);

    assign hit         = (ball_w >= top_w) && (ball_w <= bot_w);
    assign top_edge    = (ball_w == top_w);
    assign bottom_edge = (ball_w == bot_w);

endmodule

// File: rtl/ball_ctrl.sv
// Pong ball controller: serve timing, wall/paddle reflection and scoring.
// Optional build macro PADDLE_SPIN_EN lets paddle edge hits steer the ball.
module ball_ctrl
    import pong_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int BIT_OF_WIDTH = 3,
    parameter int PADDLE_LEN   = 3,
    parameter int SERVE_TICKS  = 4,
    parameter int MAX_SCORE    = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    move_tick,
    input  logic [BIT_OF_WIDTH-1:0] x_pos,
    input  logic [BIT_OF_WIDTH-1:0] y_pos,
    input  logic [BIT_OF_WIDTH-1:0] pad_l_y,
    input  logic [BIT_OF_WIDTH-1:0] pad_r_y,
    output logic [3:0]              vector,
    output logic                    en,
    output logic                    endgame,
    output logic [3:0]              score_l,
    output logic [3:0]              score_r
);

    localparam int CNT_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS + 1) : 1;
    localparam logic [CNT_W-1:0]        SERVE_LAST = CNT_W'(SERVE_TICKS - 1);
    localparam logic [3:0]              SCORE_MAX  = 4'(MAX_SCORE);
    localparam logic [BIT_OF_WIDTH-1:0] ROW_LAST   = BIT_OF_WIDTH'(WIDTH - 1);
    localparam logic [BIT_OF_WIDTH-1:0] COL_LEFT   = BIT_OF_WIDTH'(1);
    localparam logic [BIT_OF_WIDTH-1:0] COL_RIGHT  = BIT_OF_WIDTH'(WIDTH - 2);

    state_t           state_q, state_d;
    logic [1:0]       vx_q, vx_d;
    logic [1:0]       vy_q, vy_d;
    logic [3:0]       score_l_q, score_l_d;
    logic [3:0]       score_r_q, score_r_d;
    logic [CNT_W-1:0] serve_cnt_q, serve_cnt_d;
    logic [1:0]       serve_dir_q, serve_dir_d;
    logic             right_scored_q, right_scored_d;

    logic hit_l, top_l, bot_l;
    logic hit_r, top_r, bot_r;

    paddle_hit #(
        .BIT_OF_WIDTH (BIT_OF_WIDTH),
        .PADDLE_LEN   (PADDLE_LEN)
    ) u_hit_l (
        .ball_y      (y_pos),
        .pad_y       (pad_l_y),
        .hit         (hit_l),
        .top_edge    (top_l),
        .bottom_edge (bot_l)
    );

    paddle_hit #(
        .BIT_OF_WIDTH (BIT_OF_WIDTH),
        .PADDLE_LEN   (PADDLE_LEN)
    ) u_hit_r (
        .ball_y      (y_pos),
        .pad_y       (pad_r_y),
        .hit         (hit_r),
        .top_edge    (top_r),
        .bottom_edge (bot_r)
    );

`ifndef PADDLE_SPIN_EN
    logic edge_unused;
    assign edge_unused = ^{top_l, bot_l, top_r, bot_r};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            vx_q           <= DIR_HOLD;
            vy_q           <= DIR_HOLD;
            score_l_q      <= '0;
            score_r_q      <= '0;
            serve_cnt_q    <= '0;
            serve_dir_q    <= DIR_NEG;
            right_scored_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            vx_q           <= vx_d;
            vy_q           <= vy_d;
            score_l_q      <= score_l_d;
            score_r_q      <= score_r_d;
            serve_cnt_q    <= serve_cnt_d;
            serve_dir_q    <= serve_dir_d;
            right_scored_q <= right_scored_d;
        end
    end

    logic [1:0] x_next;
    logic [1:0] y_next;
    logic       miss;
    logic [3:0] new_score;

    always_comb begin
        state_d        = state_q;
        vx_d           = vx_q;
        vy_d           = vy_q;
        score_l_d      = score_l_q;
        score_r_d      = score_r_q;
        serve_cnt_d    = serve_cnt_q;
        serve_dir_d    = serve_dir_q;
        right_scored_d = right_scored_q;
        x_next         = vx_q;
        y_next         = vy_q;
        miss           = 1'b0;
        new_score      = '0;

        case (state_q)
            IDLE: ;

            SERVE: begin
                if (move_tick) begin
                    if (serve_cnt_q == SERVE_LAST) begin
                        state_d     = PLAY;
                        vx_d        = serve_dir_q;
                        vy_d        = DIR_POS;
                        serve_cnt_d = '0;
                    end else begin
                        serve_cnt_d = serve_cnt_q + CNT_W'(1);
                    end
                end
            end

            PLAY: begin
                if (move_tick) begin
                    if (x_pos == COL_LEFT && vx_q == DIR_NEG) begin
                        if (hit_l) begin
                            x_next = DIR_POS;
`ifdef PADDLE_SPIN_EN
                            if (top_l)
                                y_next = DIR_NEG;
                            else if (bot_l)
                                y_next = DIR_POS;
`endif
                        end else begin
                            miss           = 1'b1;
                            right_scored_d = 1'b1;
                        end
                    end else if (x_pos == COL_RIGHT && vx_q == DIR_POS) begin
                        if (hit_r) begin
                            x_next = DIR_NEG;
`ifdef PADDLE_SPIN_EN
                            if (top_r)
                                y_next = DIR_NEG;
                            else if (bot_r)
                                y_next = DIR_POS;
`endif
                        end else begin
                            miss           = 1'b1;
                            right_scored_d = 1'b0;
                        end
                    end

                    // Wall check after spin so a corner hit never drives into the wall.
                    if (y_pos == '0 && y_next == DIR_NEG)
                        y_next = dir_flip(y_next);
                    else if (y_pos == ROW_LAST && y_next == DIR_POS)
                        y_next = dir_flip(y_next);

                    if (miss) begin
                        state_d = POINT;
                    end else begin
                        vx_d = x_next;
                        vy_d = y_next;
                    end
                end
            end

            POINT: begin
                if (right_scored_q) begin
                    new_score   = (score_r_q < SCORE_MAX) ? score_r_q + 4'd1 : score_r_q;
                    score_r_d   = new_score;
                    serve_dir_d = DIR_NEG;
                end else begin
                    new_score   = (score_l_q < SCORE_MAX) ? score_l_q + 4'd1 : score_l_q;
                    score_l_d   = new_score;
                    serve_dir_d = DIR_POS;
                end
                if (new_score == SCORE_MAX) begin
                    state_d = OVER;
                end else begin
                    state_d     = SERVE;
                    serve_cnt_d = '0;
                    vx_d        = DIR_HOLD;
                    vy_d        = DIR_HOLD;
                end
            end

            OVER: ;

            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d        = SERVE;
            vx_d           = DIR_HOLD;
            vy_d           = DIR_HOLD;
            score_l_d      = '0;
            score_r_d      = '0;
            serve_cnt_d    = '0;
            serve_dir_d    = DIR_NEG;
            right_scored_d = 1'b0;
        end
    end

    assign vector  = {vx_q, vy_q};
    assign en      = (state_q == PLAY) || (state_q == OVER);
    assign endgame = (state_q == OVER);
    assign score_l = score_l_q;
    assign score_r = score_r_q;

endmodule
